// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg: shared types and helpers for the clk_div_monitor slice.
// Holds the FSM state enum, the default counter width and a saturating
// increment used by the measurement counters.
package clk_mon_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      HIGH = 2'd2,
      LOW  = 2'd3
   } state_t;

   localparam int unsigned CLK_MON_CNT_W = 16;

   // Increment v by one, holding at max_v once reached.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
      return (v >= max_v) ? max_v : v + 32'd1;
   endfunction

endpackage

// File: rtl/clk_mon_edge.sv
// clk_mon_edge: two-flop synchronizer for the asynchronous clk_in followed by
// a delay register; emits single-cycle rise/fall strobes in the clk domain.
module clk_mon_edge
(
   input  logic clk,
   input  logic rst,
   input  logic clk_in,
   output logic rise,
   output logic fall
);

   logic s_meta;
   logic s_sync;
   logic s_dly;

   // Synchronize clk_in and keep one cycle of history for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_meta <= 1'b0;
         s_sync <= 1'b0;
         s_dly  <= 1'b0;
      end else begin
         s_meta <= clk_in;
         s_sync <= s_meta;
         s_dly  <= s_sync;
      end
   end

   assign rise = s_sync & ~s_dly;
   assign fall = ~s_sync & s_dly;

endmodule

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures high time, low time and period of a slow clock
// (clk_in) in cycles of clk, checks duty within DUTY_TOL and flags a stall.
// Optional feature: define CLK_DIV_MONITOR_DUTY_EN to build the duty
// comparator; otherwise duty_ok is tied low.
module clk_div_monitor
   import clk_mon_pkg::*;
#(
   parameter int unsigned CNT_W    = CLK_MON_CNT_W,
   parameter logic [15:0] TIMEOUT  = 16'd1000,
   parameter int unsigned DUTY_TOL = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_in,
   input  logic             start,
   output logic             busy,
   output logic             valid,
   output logic             timeout,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] low_cnt,
   output logic [CNT_W:0]   period,
   output logic             duty_ok
);

   // Watchdog is never narrower than TIMEOUT so a small CNT_W still times out.
   localparam int unsigned      WD_W    = (CNT_W > 16) ? CNT_W : 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state;
   state_t           state_next;
   logic             rise;
   logic             fall;
   logic             accept;
   logic             done;
   logic             wd_fire;
   logic [CNT_W-1:0] h;
   logic [CNT_W-1:0] l;
   logic [WD_W-1:0]  wd;

   clk_mon_edge u_edge (
      .clk    (clk),
      .rst    (rst),
      .clk_in (clk_in),
      .rise   (rise),
      .fall   (fall)
   );

   assign busy = (state != IDLE);

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic plus the accept/done/watchdog-expiry strobes.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      done       = 1'b0;
      wd_fire    = 1'b0;
      if ((state != IDLE) && !rise && !fall && ((wd + WD_W'(1)) == WD_W'(TIMEOUT)))
         wd_fire = 1'b1;
      case (state)
         IDLE: begin
            if (start && !valid && !timeout) begin
               accept     = 1'b1;
               state_next = ARM;
            end
         end
         ARM: begin
            if (wd_fire)   state_next = IDLE;
            else if (rise) state_next = HIGH;
         end
         HIGH: begin
            if (wd_fire)   state_next = IDLE;
            else if (fall) state_next = LOW;
         end
         LOW: begin
            if (rise) begin
               done       = 1'b1;
               state_next = IDLE;
            end else if (wd_fire) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Counters, watchdog, result registers and output pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         h        <= '0;
         l        <= '0;
         wd       <= '0;
         valid    <= 1'b0;
         timeout  <= 1'b0;
         high_cnt <= '0;
         low_cnt  <= '0;
         period   <= '0;
      end else begin
         valid   <= done;
         timeout <= wd_fire;

         if (accept || rise || fall) wd <= '0;
         else if (state != IDLE)     wd <= wd + WD_W'(1);

         if ((state == ARM) && rise)       h <= CNT_W'(1);
         else if ((state == HIGH) && !fall) h <= CNT_W'(sat_inc(32'(h), 32'(CNT_MAX)));

         if ((state == HIGH) && fall)     l <= CNT_W'(1);
         else if ((state == LOW) && !rise) l <= CNT_W'(sat_inc(32'(l), 32'(CNT_MAX)));

         if (done) begin
            high_cnt <= h;
            low_cnt  <= l;
            period   <= {1'b0, h} + {1'b0, l};
         end
      end
   end

`ifdef CLK_DIV_MONITOR_DUTY_EN
   logic [CNT_W-1:0] diff;

   // Absolute high/low difference of the counts being registered.
   always_comb begin
      diff = (h >= l) ? (h - l) : (l - h);
   end

   // Duty verdict registered alongside the results.
   always_ff @(posedge clk) begin
      if (rst)       duty_ok <= 1'b0;
      else if (done) duty_ok <= (32'(diff) <= DUTY_TOL);
   end
`else
   assign duty_ok = 1'b0;
`endif

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

- Measures high time, low time and period of a slow clock-like input in cycles of the fast system clock.
- Checks that the measured waveform is 50%-duty within a tolerance and raises a timeout if the input stalls.
- Sits directly downstream of the odd-ratio clock divider and consumes its divided output as `clk_in`.
- Used in bring-up and self-test to confirm that divider ratio and duty correction are correct.

## Interface
- `CNT_W`, 16: width of all measurement counters.
- `TIMEOUT`, 16'd1000: cycles without an edge before the timeout error; must be < 2^CNT_W.
- `DUTY_TOL`, 1: max allowed |high_cnt − low_cnt| for `duty_ok`.
- `clk`  in  1  system clock; must be ≥ 4× the frequency of `clk_in`.
- `rst`  in  1  reset, synchronous, active-high.
- `clk_in`  in  1  divided clock under test; asynchronous to `clk`.
- `start`  in  1  one-cycle request to begin a measurement.
- `busy`  out  1  measurement in progress.
- `valid`  out  1  one-cycle pulse; results updated.
- `timeout`  out  1  one-cycle pulse; measurement aborted.
- `high_cnt`  out  CNT_W  cycles `clk_in` was high.
- `low_cnt`  out  CNT_W  cycles `clk_in` was low.
- `period`  out  CNT_W+1  `high_cnt + low_cnt`, no overflow.
- `duty_ok`  out  1  duty within tolerance; meaningful when `valid`.

## Operation
- `clk_in` passes through a 2-flop synchronizer, then a delay register.
- Edge detection: `rise = s & ~s_d`, `fall = ~s & s_d`.
- IDLE: `busy` = 0. `start` → ARM, watchdog cleared.
- ARM: wait for `rise` → HIGH with `h` = 1.
- HIGH: `h` += 1 per cycle. On `fall` → LOW with `l` = 1; the fall cycle is not added to `h`.
- LOW: `l` += 1 per cycle. On `rise`:
  - Register `high_cnt` = h, `low_cnt` = l, `period` = h + l and `duty_ok`.
  - Go to IDLE.
- Result: `high_cnt` equals the number of `clk` cycles `clk_in` was sampled high.
- Watchdog: active in ARM, HIGH and LOW; cleared on every `rise` or `fall`.
  - When it reaches `TIMEOUT`: pulse `timeout`, go to IDLE.
  - Result registers keep their previous values; `valid` is not asserted.
- `h` and `l` saturate at 2^CNT_W − 1. Unreachable when `TIMEOUT` is legal; the bench checks it anyway.
- `start` while `busy` is ignored. `start` in the same cycle as a `valid` or `timeout` pulse is also ignored.
- `rst` at any time:
  - State → IDLE.
  - All outputs, counters and synchronizer flops → 0.

## Timing
- A `clk_in` transition becomes `rise`/`fall` 2–3 `clk` cycles later, depending on sampling phase. The latency is common to all edges, so it cancels in the measurements.
- `busy` rises the cycle after `start` is accepted. It falls in the same cycle as the `valid` or `timeout` pulse.
- `valid` and results appear 1 cycle after the closing `rise` is detected.
- `duty_ok` is registered together with the results.
- Minimum measurement: `clk_in` high ≥ 2 and low ≥ 2 `clk` cycles. Shorter pulses may be missed; such pulses are out of contract.

## Configuration
- `CLK_DIV_MONITOR_DUTY_EN` defined: `duty_ok` = (|high_cnt − low_cnt| ≤ DUTY_TOL), computed on the cycle results are registered.
- Not defined: duty comparator is not built and `duty_ok` is tied 0. The port stays present.

## Structure
- Package `clk_mon_pkg`:
  - State enum: IDLE, ARM, HIGH, LOW.
  - Default `CNT_W` constant.
  - Saturating-increment function.
- Sub-module `clk_mon_edge`: 2-flop synchronizer plus edge detector. Outputs `rise` and `fall`; reset clears all flops.
- Top level: FSM, counters, watchdog, result registers, duty comparator.

## Test plan
- `clk_in` high 5 / low 4 `clk` cycles, pulse `start`, DUTY_EN, TOL = 1 → `valid` with `high_cnt` = 5, `low_cnt` = 4, `period` = 9, `duty_ok` = 1.
- `clk_in` high 7 / low 2 → `high_cnt` = 7, `low_cnt` = 2, `duty_ok` = 0. Without the macro, `duty_ok` = 0 in every case.
- `clk_in` held low, `start`, TIMEOUT = 20 → `timeout` pulse 20 cycles after ARM entry, `busy` → 0, previous results unchanged.
- `start` pulsed again mid-measurement → ignored; single `valid` with correct counts.
- `rst` asserted during HIGH → next cycle all outputs 0, state IDLE. A new `start` then measures correctly.
- Real odd divider DIV = 3 fed from a source clock at ¼ of `clk` → `period` = 12, `high_cnt` = 6, `low_cnt` = 6, `duty_ok` = 1.
